// File: rtl/serial_hba_bridge.sv
// Serial-to-HBA bridge: decodes CMD/REG/LEN[/DATA] byte frames from a UART into
// HBA master bursts, returns read data bytes and a final status byte.
//
// state       | meaning
// ------------+---------------------------------------------
// IDLE        | waiting for CMD byte
// GET_REG     | waiting for register address byte
// GET_LEN     | waiting for burst length byte
// GET_DATA    | waiting for next write data byte
// BUS_REQ     | bus requested, waiting for grant
// BUS_XFER    | transfer driven, waiting for xferack
// SEND_DATA   | returning one read byte on tx
// SEND_STATUS | returning 0xAC (ok) or 0x56 (bus error)
module serial_hba_bridge #(
   parameter int DBUS_WIDTH        = 8,
   parameter int PERIPH_ADDR_WIDTH = 4,
   parameter int REG_ADDR_WIDTH    = 8,
   parameter int LEN_WIDTH         = 4,
   parameter int BUS_TIMEOUT       = 255,
   parameter int RX_TIMEOUT        = 50000
) (
   input  logic                                      hba_clk,
   input  logic                                      hba_reset_n,
   input  logic [7:0]                                rx_data,
   input  logic                                      rx_valid,
   output logic                                      rx_rd,
   output logic [7:0]                                tx_data,
   output logic                                      tx_wr,
   input  logic                                      tx_busy,
   input  logic                                      hba_mgrant,
   input  logic                                      hba_xferack,
   input  logic [DBUS_WIDTH-1:0]                     hba_dbus,
   output logic                                      master_request,
   output logic [PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH-1:0] master_abus,
   output logic                                      master_rnw,
   output logic                                      master_select,
   output logic [DBUS_WIDTH-1:0]                     master_dbus,
   output logic                                      busy,
   output logic                                      frame_err
);

   localparam int ABUS_W = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH;
   localparam int BCNT_W = $clog2(BUS_TIMEOUT + 1);
   localparam int RCNT_W = $clog2(RX_TIMEOUT + 1);
   localparam logic [BCNT_W-1:0] BUS_LD = BCNT_W'(BUS_TIMEOUT);
   localparam logic [RCNT_W-1:0] RX_LD  = RCNT_W'(RX_TIMEOUT - 1);
   localparam logic [7:0] ST_ACK = 8'hAC;
   localparam logic [7:0] ST_NAK = 8'h56;

   typedef enum logic [2:0] {
      S_IDLE, S_GET_REG, S_GET_LEN, S_GET_DATA,
      S_BUS_REQ, S_BUS_XFER, S_SEND_DATA, S_SEND_STATUS
   } state_t;

   state_t                      state_q, state_d;
   logic                        rnw_q, rnw_d;
   logic                        fixed_q, fixed_d;
   logic [PERIPH_ADDR_WIDTH-1:0] periph_q, periph_d;
   logic [REG_ADDR_WIDTH-1:0]   reg_addr_q, reg_addr_d;
   logic [LEN_WIDTH-1:0]        rem_q, rem_d;
   logic [7:0]                  wdata_q, wdata_d;
   logic                        err_q, err_d;
   logic                        rx_ign_q, rx_ign_d;
   logic                        tx_ign_q, tx_ign_d;
   logic [BCNT_W-1:0]           bus_cnt_q, bus_cnt_d;
   logic [RCNT_W-1:0]           rx_cnt_q, rx_cnt_d;
   logic                        req_q, req_d;
   logic                        sel_q, sel_d;
   logic                        mrnw_q, mrnw_d;
   logic [ABUS_W-1:0]           abus_q, abus_d;
   logic [DBUS_WIDTH-1:0]       mdbus_q, mdbus_d;
   logic [7:0]                  txd_q, txd_d;
   logic                        ferr_q, ferr_d;
   logic                        busy_q, busy_d;

   logic rx_take, tx_go, bus_ack, bus_to, bus_done, rx_to, rx_wait, bus_state, err_now;

   always_comb begin
      rx_wait   = state_q inside {S_GET_REG, S_GET_LEN, S_GET_DATA};
      bus_state = state_q inside {S_BUS_REQ, S_BUS_XFER};
      // reset gates the combinational rx strobe so it is low while held in reset
      rx_take   = hba_reset_n && rx_valid && !rx_ign_q &&
                  (rx_wait || state_q == S_IDLE);
      tx_go     = (state_q inside {S_SEND_DATA, S_SEND_STATUS}) && !tx_busy && !tx_ign_q;
      bus_ack   = (state_q == S_BUS_XFER) && hba_xferack;
      bus_to    = bus_state && (bus_cnt_q == '0) && !bus_ack;
      bus_done  = bus_ack || bus_to;
   end

   always_comb begin
      state_d    = state_q;
      rnw_d      = rnw_q;
      fixed_d    = fixed_q;
      periph_d   = periph_q;
      reg_addr_d = reg_addr_q;
      rem_d      = rem_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      req_d      = req_q;
      sel_d      = sel_q;
      mrnw_d     = mrnw_q;
      abus_d     = abus_q;
      mdbus_d    = mdbus_q;
      txd_d      = txd_q;
      ferr_d     = 1'b0;
      rx_ign_d   = rx_take;
      tx_ign_d   = tx_go;
      rx_to      = 1'b0;
      err_now    = err_q | bus_to;

      if (rx_wait && !rx_valid) begin
         if (rx_cnt_q == '0) rx_to = 1'b1;
         rx_cnt_d = (rx_cnt_q == '0) ? rx_cnt_q : rx_cnt_q - RCNT_W'(1);
      end else begin
         rx_cnt_d = RX_LD;
      end

      if (bus_state) begin
         bus_cnt_d = (bus_cnt_q == '0) ? bus_cnt_q : bus_cnt_q - BCNT_W'(1);
      end else begin
         bus_cnt_d = BUS_LD;
      end

      if (rx_to) begin
         state_d = S_IDLE;
         ferr_d  = 1'b1;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (rx_take) begin
               rnw_d    = rx_data[7];
               fixed_d  = rx_data[6];
               periph_d = rx_data[PERIPH_ADDR_WIDTH-1:0];
               state_d  = S_GET_REG;
            end
            S_GET_REG: if (rx_take) begin
               reg_addr_d = rx_data[REG_ADDR_WIDTH-1:0];
               state_d    = S_GET_LEN;
            end
            S_GET_LEN: if (rx_take) begin
               rem_d = rx_data[LEN_WIDTH-1:0];
               if (rnw_q) begin
                  req_d   = 1'b1;
                  state_d = S_BUS_REQ;
               end else begin
                  state_d = S_GET_DATA;
               end
            end
            S_GET_DATA: if (rx_take) begin
               wdata_d = rx_data;
               req_d   = 1'b1;
               state_d = S_BUS_REQ;
            end
            S_BUS_REQ, S_BUS_XFER: begin
               if (bus_done) begin
                  req_d   = 1'b0;
                  sel_d   = 1'b0;
                  mrnw_d  = 1'b0;
                  abus_d  = '0;
                  mdbus_d = '0;
                  err_d   = err_now;
                  if (!fixed_q) reg_addr_d = reg_addr_q + REG_ADDR_WIDTH'(1);
                  if (rnw_q) begin
                     txd_d   = bus_ack ? hba_dbus : 8'h00;
                     state_d = S_SEND_DATA;
                  end else if (rem_q == '0) begin
                     txd_d   = err_now ? ST_NAK : ST_ACK;
                     state_d = S_SEND_STATUS;
                  end else begin
                     rem_d   = rem_q - LEN_WIDTH'(1);
                     state_d = S_GET_DATA;
                  end
               end else if (state_q == S_BUS_REQ && hba_mgrant) begin
                  sel_d   = 1'b1;
                  mrnw_d  = rnw_q;
                  abus_d  = {periph_q, reg_addr_q};
                  mdbus_d = rnw_q ? '0 : wdata_q;
                  state_d = S_BUS_XFER;
               end
            end
            S_SEND_DATA: if (tx_go) begin
               if (rem_q == '0) begin
                  txd_d   = err_q ? ST_NAK : ST_ACK;
                  state_d = S_SEND_STATUS;
               end else begin
                  rem_d   = rem_q - LEN_WIDTH'(1);
                  req_d   = 1'b1;
                  state_d = S_BUS_REQ;
               end
            end
            S_SEND_STATUS: if (tx_go) begin
               err_d   = 1'b0;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge hba_clk or negedge hba_reset_n) begin
      if (!hba_reset_n) begin
         state_q    <= S_IDLE;
         rnw_q      <= 1'b0;
         fixed_q    <= 1'b0;
         periph_q   <= '0;
         reg_addr_q <= '0;
         rem_q      <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         rx_ign_q   <= 1'b0;
         tx_ign_q   <= 1'b0;
         bus_cnt_q  <= '0;
         rx_cnt_q   <= '0;
         req_q      <= 1'b0;
         sel_q      <= 1'b0;
         mrnw_q     <= 1'b0;
         abus_q     <= '0;
         mdbus_q    <= '0;
         txd_q      <= '0;
         ferr_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rnw_q      <= rnw_d;
         fixed_q    <= fixed_d;
         periph_q   <= periph_d;
         reg_addr_q <= reg_addr_d;
         rem_q      <= rem_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         rx_ign_q   <= rx_ign_d;
         tx_ign_q   <= tx_ign_d;
         bus_cnt_q  <= bus_cnt_d;
         rx_cnt_q   <= rx_cnt_d;
         req_q      <= req_d;
         sel_q      <= sel_d;
         mrnw_q     <= mrnw_d;
         abus_q     <= abus_d;
         mdbus_q    <= mdbus_d;
         txd_q      <= txd_d;
         ferr_q     <= ferr_d;
         busy_q     <= busy_d;
      end
   end

   assign rx_rd          = rx_take;
   assign tx_wr          = tx_go;
   assign tx_data        = txd_q;
   assign master_request = req_q;
   assign master_select  = sel_q;
   assign master_rnw     = mrnw_q;
   assign master_abus    = abus_q;
   assign master_dbus    = mdbus_q;
   assign busy           = busy_q;
   assign frame_err      = ferr_q;

endmodule
